data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory controller that sits directly downstream of the core datapath's load/store path. It accepts one load or store per handshake and applies RV32I width rules (byte, halfword, word; sign- or zero-extended). Wait states are configurable, and the result comes back as a single-cycle response pulse. It replaces the datapath's internal combinational data array so the core can be tested against memory with non-zero latency.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- WAIT_CYCLES, 1: extra wait cycles before the access; legal range 0..15.
- clk  input  1  clock; everything is sampled on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (IDLE only).
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3.
- req_addr  input  32  byte address (the core's ALUResult).
- req_wdata  input  32  store data (the core's RD2).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and for faults.
- rsp_misaligned  output  1  valid with rsp_valid; access was misaligned.
- rsp_illegal  output  1  valid with rsp_valid; funct3 is illegal for the direction.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch write, funct3, addr and wdata; load the wait counter with WAIT_CYCLES; go to WAIT.
- WAIT:
  - While counter != 0: decrement.
  - At counter == 0: perform the access at that edge, register the response fields, go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - No backpressure; req_ready = 0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets rsp_illegal.
- Misalignment: halfword with addr[0] = 1, or word with addr[1:0] != 0, sets rsp_misaligned.
- Faults:
  - Illegal takes priority over misaligned; only one flag is set.
  - A faulting request does not modify memory, returns rsp_rdata = 0, and still takes the full latency.
- Word index is addr[AW+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
- Stores:
  - Byte lane = addr[1:0]; SB writes wdata[7:0] to that lane.
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
  - Unselected lanes are preserved.
- Loads: select lane(s) by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_misaligned = 0, rsp_illegal = 0; state = IDLE; counter = 0.
- Reset does not clear memory contents; simulation initialises them to 0.
- Latency:
  - Request accepted at edge E0.
  - Access occurs at edge E0 + WAIT_CYCLES + 1.
  - rsp_valid is high in the cycle following that edge.
  - Example: with WAIT_CYCLES = 0, rsp_valid rises one cycle after the accept cycle's edge + 1.
- Throughput: one request every WAIT_CYCLES + 3 cycles.
- Back-to-back: req_valid held high through RESP is accepted in the next IDLE cycle only.
- Reset mid-operation:
  - Reset asserted in WAIT before the access edge: the pending store is dropped (no write) and no response is produced.
  - Reset at the access edge itself takes priority: no write.
- A store followed by a load to the same word returns the new data, since the access edges are strictly ordered.
- Request inputs are ignored outside IDLE; changes to them after acceptance have no effect.

## Structure
- Shared package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, WAIT, RESP);
  - the default DEPTH_WORDS.
- Sub-module lsu_align (combinational): takes funct3, addr[1:0], wdata and the read word. It produces:
  - the 4-bit byte enable and the lane-shifted store data;
  - the extended load data;
  - the misaligned and illegal flags.
- Top level: the FSM, wait counter, request latch and byte-enabled memory array.

## Test plan
- SW 0x8000_00FF to addr 0x10, then LW 0x10 (WAIT_CYCLES = 0) -> rsp_rdata = 0x8000_00FF; each rsp_valid arrives 2 cycles after acceptance.
- SB 0xAB to addr 0x21 over word 0x11223344 -> word becomes 0x1122AB44. Then LB 0x21 -> 0xFFFF_FFAB; LBU 0x21 -> 0x0000_00AB.
- SH 0x8001 to 0x32, then LH 0x32 -> 0xFFFF_8001; LHU 0x32 -> 0x0000_8001; lanes 0 and 1 unchanged.
- LW at 0x06 -> rsp_misaligned = 1, rdata = 0. SW at 0x05 -> misaligned and memory unchanged. Store with funct3 = 100 -> rsp_illegal = 1, rsp_misaligned = 0.
- WAIT_CYCLES = 3: accept at cycle 0 -> rsp_valid in cycle 5. With req_valid held high, req_ready is low in cycles 1-5 and the next acceptance is in cycle 6.
- SW to 0x40 with reset pulsed during WAIT -> no rsp_valid, a later LW 0x40 returns the old value, and all outputs show reset values the cycle after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 1024;
  localparam int unsigned WAIT_W          = 4;
  localparam int unsigned XLEN            = 32;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured at acceptance
  typedef struct packed {
    logic            write;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational RV32I width handling: byte enables, store lane steering,
// load extraction/extension and fault classification.
module lsu_align
  import dmem_pkg::*;
(
  input  logic            write_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_c_o,
  output logic [XLEN-1:0] wdata_c_o,
  output logic [XLEN-1:0] rdata_c_o,
  output logic            misaligned_c_o,
  output logic            illegal_c_o
);

  logic       fault;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  // Classify funct3 for the direction; illegal masks misaligned
  always_comb begin
    illegal_c_o    = 1'b0;
    misaligned_c_o = 1'b0;
    if (write_i) begin
      illegal_c_o = !(funct3_i inside {F3_B, F3_H, F3_W});
    end else begin
      illegal_c_o = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    if (!illegal_c_o) begin
      case (funct3_i[1:0])
        2'b01:   misaligned_c_o = lane_i[0];
        2'b10:   misaligned_c_o = (lane_i != 2'b00);
        default: misaligned_c_o = 1'b0;
      endcase
    end
  end

  assign fault = illegal_c_o | misaligned_c_o;

  // Store byte enables and replicated store data; no lanes on faults or loads
  always_comb begin
    be_c_o    = 4'b0000;
    wdata_c_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_c_o    = 4'b0001 << lane_i;
        wdata_c_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_c_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_c_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_c_o    = 4'b1111;
        wdata_c_o = wdata_i;
      end
    endcase
    if (fault || !write_i) begin
      be_c_o = 4'b0000;
    end
  end

  // Lane selection from the addressed word
  always_comb begin
    byte_sel = rword_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      2'd3:    byte_sel = rword_i[31:24];
      default: byte_sel = rword_i[7:0];
    endcase
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  // Load extension; zero for stores and faulting accesses
  always_comb begin
    rdata_c_o = '0;
    case (funct3_i)
      F3_B:    rdata_c_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_c_o = {24'd0, byte_sel};
      F3_H:    rdata_c_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_c_o = {16'd0, half_sel};
      F3_W:    rdata_c_o = rword_i;
      default: rdata_c_o = '0;
    endcase
    if (fault || write_i) begin
      rdata_c_o = '0;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store per handshake, configurable wait
// states, byte-enabled word array, single-cycle response pulse.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = 1
)
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_misaligned,
  output logic            rsp_illegal
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  req_t              req_q, req_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_mis_q, rsp_mis_d;
  logic            rsp_ill_q, rsp_ill_d;

  logic            access_c;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rword;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_ext;
  logic            mis_c;
  logic            ill_c;
  logic            unused_addr_hi;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // Upper address bits wrap and are deliberately dropped
  assign widx           = req_q.addr[AW+1:2];
  assign unused_addr_hi = ^req_q.addr[XLEN-1:AW+2];
  assign rword          = mem_q[widx];

  lsu_align u_align (
    .write_i        (req_q.write),
    .funct3_i       (req_q.funct3),
    .lane_i         (req_q.addr[1:0]),
    .wdata_i        (req_q.wdata),
    .rword_i        (rword),
    .be_c_o         (be),
    .wdata_c_o      (wdata_sh),
    .rdata_c_o      (rdata_ext),
    .misaligned_c_o (mis_c),
    .illegal_c_o    (ill_c)
  );

  // Next-state, request latch and registered response fields
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_ill_d   = rsp_ill_q;
    access_c    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_d.write  = req_write;
          req_d.funct3 = req_funct3;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          cnt_d        = WAIT_W'(WAIT_CYCLES);
          state_d      = WAIT;
          req_ready_d  = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          access_c    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata_ext;
          rsp_mis_d   = mis_c;
          rsp_ill_d   = ill_c;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_ill_q   <= rsp_ill_d;
    end
  end

  // Byte-enabled write at the access edge; reset on that edge wins
  always_ff @(posedge clk) begin
    if (access_c && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_misaligned = rsp_mis_q;
  assign rsp_illegal    = rsp_ill_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl; instance 0 has no wait
// states, instance 1 has three.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_mis    [2];
  logic        rsp_ill    [2];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_misaligned(rsp_mis[0]), .rsp_illegal(rsp_ill[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_misaligned(rsp_mis[1]), .rsp_illegal(rsp_ill[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl [2][DEPTH];

  function automatic int wc(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RV32I width rules on a byte view of each word
  function automatic void model_access(input int k, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic mis,
                                       output logic ill);
    int          idx;
    int          lane;
    int          size;
    logic [7:0]  b [4];
    logic [63:0] v;
    idx  = int'((addr >> 2) % DEPTH);
    lane = int'(addr % 4);
    if (wr) ill = (f3 > 3'd2);
    else    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    mis  = !ill && ((lane % size) != 0);
    rd   = 32'd0;
    if (ill || mis) return;
    for (int i = 0; i < 4; i++) b[i] = 8'(mdl[k][idx] >> (8 * i));
    if (wr) begin
      for (int i = 0; i < size; i++) b[lane + i] = 8'(wd >> (8 * i));
      mdl[k][idx] = {b[3], b[2], b[1], b[0]};
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v = v | (64'(b[lane + i]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      rd = 32'(v);
    end
  endfunction

  task automatic reset_values(input int k, input string tag);
    check({tag, "_ready"}, 32'(req_ready[k]), 32'd1);
    check({tag, "_valid"}, 32'(rsp_valid[k]), 32'd0);
    check({tag, "_rdata"}, rsp_rdata[k], 32'd0);
    check({tag, "_mis"},   32'(rsp_mis[k]),   32'd0);
    check({tag, "_ill"},   32'(rsp_ill[k]),   32'd0);
  endtask

  // One full transaction checked against the model
  task automatic xact(input int k, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                      output logic ill);
    logic [31:0] erd;
    logic        emis, eill;
    int          cyc;
    bit          got;
    @(negedge clk);
    check("ready_idle", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1; req_write[k] = wr; req_funct3[k] = f3;
    req_addr[k] = addr; req_wdata[k] = wd;
    model_access(k, wr, f3, addr, wd, erd, emis, eill);
    @(negedge clk);
    // scramble inputs after acceptance; they must be ignored
    req_valid[k] = 1'b0; req_write[k] = 1'($urandom); req_funct3[k] = 3'($urandom);
    req_addr[k] = $urandom; req_wdata[k] = $urandom;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (rsp_valid[k]) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(cyc), 32'(wc(k) + 2));
    check("rdata", rsp_rdata[k], erd);
    check("misaligned", 32'(rsp_mis[k]), 32'(emis));
    check("illegal", 32'(rsp_ill[k]), 32'(eill));
    rd  = rsp_rdata[k];
    mis = rsp_mis[k];
    ill = rsp_ill[k];
  endtask

  logic [31:0] rd, old, erd;
  logic        mis, ill, emis, eill;
  logic [2:0]  lf [5];
  int          bad;
  bit          got;

  initial begin
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) mdl[k][i] = 32'd0;
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_funct3[k] = 3'd0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    reset_values(0, "rst0");
    reset_values(1, "rst1");
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Preload a working set so no check depends on power-up contents
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++)
        xact(k, 1'b1, 3'd2, 32'(i * 4), $urandom | 32'h0100_0001, rd, mis, ill);

    // Word store/load, zero wait states
    xact(0, 1'b1, 3'd2, 32'h10, 32'h8000_00FF, rd, mis, ill);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, mis, ill);
    check("lw_0x10", rd, 32'h8000_00FF);

    // Byte store into a known word, signed/unsigned byte loads
    xact(0, 1'b1, 3'd2, 32'h20, 32'h1122_3344, rd, mis, ill);
    xact(0, 1'b1, 3'd0, 32'h21, 32'hFFFF_FFAB, rd, mis, ill);
    xact(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, mis, ill);
    check("sb_merge", rd, 32'h1122_AB44);
    xact(0, 1'b0, 3'd0, 32'h21, 32'h0, rd, mis, ill);
    check("lb", rd, 32'hFFFF_FFAB);
    xact(0, 1'b0, 3'd4, 32'h21, 32'h0, rd, mis, ill);
    check("lbu", rd, 32'h0000_00AB);

    // Upper halfword store
    xact(0, 1'b1, 3'd2, 32'h30, 32'hCAFE_BABE, rd, mis, ill);
    xact(0, 1'b1, 3'd1, 32'h32, 32'h1234_8001, rd, mis, ill);
    xact(0, 1'b0, 3'd1, 32'h32, 32'h0, rd, mis, ill);
    check("lh", rd, 32'hFFFF_8001);
    xact(0, 1'b0, 3'd5, 32'h32, 32'h0, rd, mis, ill);
    check("lhu", rd, 32'h0000_8001);
    xact(0, 1'b0, 3'd5, 32'h30, 32'h0, rd, mis, ill);
    check("sh_low_kept", rd, 32'h0000_BABE);

    // Faults
    xact(0, 1'b0, 3'd2, 32'h06, 32'h0, rd, mis, ill);
    check("lw_mis_flag", 32'(mis), 32'd1);
    check("lw_mis_data", rd, 32'd0);
    xact(0, 1'b0, 3'd2, 32'h04, 32'h0, old, mis, ill);
    xact(0, 1'b1, 3'd2, 32'h05, 32'h5555_AAAA, rd, mis, ill);
    check("sw_mis_flag", 32'(mis), 32'd1);
    xact(0, 1'b0, 3'd2, 32'h04, 32'h0, rd, mis, ill);
    check("sw_mis_nowrite", rd, old);
    xact(0, 1'b1, 3'd4, 32'h07, 32'h1, rd, mis, ill);
    check("st_ill_flag", 32'(ill), 32'd1);
    check("st_ill_nomis", 32'(mis), 32'd0);

    // Address wrap onto word 4
    xact(0, 1'b1, 3'd2, 32'h1234_5010, 32'h0BAD_F00D, rd, mis, ill);
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, mis, ill);
    check("wrap", rd, 32'h0BAD_F00D);

    // Back-to-back with req_valid held, three wait states
    @(negedge clk);
    check("b2b_ready0", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h10; req_wdata[1] = 32'h0;
    model_access(1, 1'b0, 3'd2, 32'h10, 32'h0, erd, emis, eill);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", c), 32'(req_ready[1]), 32'(c == 6));
      check($sformatf("b2b_valid_c%0d", c), 32'(rsp_valid[1]), 32'(c == 5));
      if (c == 5) check("b2b_rdata", rsp_rdata[1], erd);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (rsp_valid[1]) got = 1'b1;
      else @(negedge clk);
    end
    check("b2b_second_rsp", 32'(got), 32'd1);

    // Reset during WAIT drops the store
    xact(1, 1'b0, 3'd2, 32'h40, 32'h0, old, mis, ill);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h40; req_wdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    reset[1] = 1'b1;
    @(negedge clk);
    reset_values(1, "rst_wait");
    reset[1] = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid[1]) bad++;
    end
    check("rst_wait_norsp", 32'(bad), 32'd0);
    xact(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, mis, ill);
    check("rst_wait_nowrite", rd, old);

    // Reset on the access edge itself
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h40; req_wdata[1] = 32'hFEED_FACE;
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_edge_pre", 32'(rsp_valid[1]), 32'd0);
    reset[1] = 1'b1;
    @(negedge clk);
    reset_values(1, "rst_edge");
    reset[1] = 1'b0;
    xact(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, mis, ill);
    check("rst_edge_nowrite", rd, old);

    // Random mix on both instances
    for (int n = 0; n < 120; n++) begin
      int          k;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      k    = n % 2;
      wr   = 1'($urandom);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else f3 = lf[$urandom_range(0, 4)];
      addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) |
             32'($urandom_range(0, 3));
      xact(k, wr, f3, addr, $urandom, rd, mis, ill);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
